// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage (PC, imem req/ack handshake, IF/ID feed); ports clk_i, rst_ni (async active-low), imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i, stall_i, redirect_i/redirect_pc_i, ifid_load_o/ifid_valid_o/ifid_inst_o/ifid_pc_o/ifid_pc4_o; `define IF_PERF_CNT_EN adds perf_fetched_o/perf_bubbles_o
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ifid_load_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_bubbles_o
`endif
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_inst_q, buf_inst_d, buf_pc_q, buf_pc_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d = buf_pc_q;
    imem_req_o = state_q == FETCH || state_q == DROP;
    // DROP keeps presenting the abandoned address; pc already holds the target
    imem_addr_o = state_q == DROP ? buf_pc_q : pc_q;
    ifid_load_o = ~stall_i | redirect_i;
    ifid_valid_o = ~redirect_i & ((state_q == FETCH & imem_ack_i) | state_q == HOLD);
    ifid_inst_o = !ifid_valid_o ? NOP : state_q == HOLD ? buf_inst_q : imem_rdata_i;
    ifid_pc_o = state_q == HOLD ? buf_pc_q : pc_q;
    ifid_pc4_o = ifid_pc_o + 32'd4;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: if (imem_ack_i) begin
        pc_d = pc_q + 32'd4;
        if (stall_i) begin
          buf_inst_d = imem_rdata_i;
          buf_pc_d = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: state_d = stall_i ? HOLD : FETCH;
      default: state_d = imem_ack_i ? FETCH : DROP;
    endcase
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~32'h3;
      buf_inst_d = buf_inst_q;
      // an unacked request in FETCH must still complete: remember its address
      buf_pc_d = state_q == FETCH ? pc_q : buf_pc_q;
      state_d = (state_q == FETCH || state_q == DROP) && !imem_ack_i ? DROP : FETCH;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      buf_inst_q <= '0;
      buf_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q <= buf_pc_d;
    end
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else if (ifid_load_o) begin
      fetched_q <= fetched_q + {31'd0, ifid_valid_o};
      bubbles_q <= bubbles_q + {31'd0, ~ifid_valid_o};
    end
  assign perf_fetched_o = fetched_q;
  assign perf_bubbles_o = bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage with a wait-state memory model
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk_i = 0, rst_ni = 0;
  logic imem_req, imem_ack = 0, stall = 0, redirect = 0;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0;
  logic ifid_load, ifid_valid;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  int errors = 0, checks = 0, nfetch = 0, nbub = 0;
  bit run = 0;
  logic [31:0] q[$];
  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .ifid_load_o(ifid_load), .ifid_valid_o(ifid_valid), .ifid_inst_o(ifid_inst),
    .ifid_pc_o(ifid_pc), .ifid_pc4_o(ifid_pc4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched), .perf_bubbles_o(perf_bubbles)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_i) if (run && rst_ni) begin
    chk(ifid_load == (~stall | redirect), "load_en", {31'd0, ifid_load}, {31'd0, ~stall | redirect});
    if (redirect) chk(!ifid_valid, "redirect_bubble", {31'd0, ifid_valid}, 32'd0);
    if (!ifid_valid) chk(ifid_inst == NOP, "bubble_nop", ifid_inst, NOP);
    chk(ifid_pc4 == ifid_pc + 32'd4, "pc4", ifid_pc4, ifid_pc + 32'd4);
    if (ifid_load && ifid_valid) begin
      chk(q.size() != 0, "unexpected_inst", ifid_pc, 32'd0);
      if (q.size() != 0) begin
        logic [31:0] e;
        e = q.pop_front();
        chk(ifid_pc == e, "ifid_pc", ifid_pc, e);
        chk(ifid_inst == (e ^ KEY), "ifid_inst", ifid_inst, e ^ KEY);
      end
      nfetch++;
    end else if (ifid_load) nbub++;
  end
  initial begin
    logic [31:0] nf, pend_addr, rt;
    bit pend;
    int wait_n, waited;
    nf = RPC;
    pend = 0;
    wait_n = 0;
    waited = 0;
    repeat (3) begin
      @(negedge clk_i);
      chk(!imem_req, "rst_req", {31'd0, imem_req}, 32'd0);
      chk(!ifid_valid && ifid_inst == NOP, "rst_bubble", ifid_inst, NOP);
      chk(ifid_load, "rst_load", {31'd0, ifid_load}, 32'd1);
      chk(ifid_pc == RPC && ifid_pc4 == RPC + 32'd4, "rst_pc", ifid_pc, RPC);
    end
    @(posedge clk_i); #1;
    rst_ni = 1;
    run = 1;
    @(negedge clk_i);
    chk(!imem_req, "idle_req", {31'd0, imem_req}, 32'd0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      if (c == 0) chk(imem_req && imem_addr == RPC, "first_req", imem_addr, RPC);
      if (pend) chk(imem_req && imem_addr == pend_addr, "req_stable", imem_addr, pend_addr);
      if (q.size() != 0) chk(!imem_req, "hold_no_req", {31'd0, imem_req}, 32'd0);
      if (imem_req) chk(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, imem_addr & ~32'h3);
      stall = c >= 10 && c < 2990 && $urandom_range(0, 3) == 0;
      redirect = c >= 10 && c < 2990 && $urandom_range(0, 11) == 0;
      rt = $urandom;
      if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
      redirect_pc = rt;
      if (imem_req && !pend) begin
        wait_n = c < 10 ? 0 : $urandom_range(0, 2);
        waited = 0;
      end
      imem_ack = imem_req && waited >= wait_n;
      if (imem_req && !imem_ack) waited++;
      imem_rdata = imem_ack ? imem_addr ^ KEY : $urandom;
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      if (redirect) begin
        q.delete();
        nf = rt & ~32'h3;
      end else if (imem_ack && imem_addr == nf) begin
        q.push_back(nf);
        nf += 32'd4;
      end
    end
    @(posedge clk_i); #1;
    imem_ack = 0;
    stall = 0;
    redirect = 0;
    @(negedge clk_i); #1;
    run = 0;
    @(posedge clk_i); #1;
    chk(q.size() == 0, "drained", q.size(), 32'd0);
    chk(nfetch > 200, "throughput", nfetch, 32'd200);
`ifdef IF_PERF_CNT_EN
    chk(perf_fetched == nfetch, "perf_fetched", perf_fetched, nfetch);
    chk(perf_bubbles == nbub, "perf_bubbles", perf_bubbles, nbub);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
